// File: rtl/rv32i_types_pkg.sv
// Shared types for the RV32I pipeline control path.
// Holds the sequencer state encoding and the per-stage load/flush bundle.
package rv32i_types;

   typedef enum logic [1:0] {
      INIT      = 2'd0,
      RUN       = 2'd1,
      MEM_STALL = 2'd2,
      LU_STALL  = 2'd3
   } pipe_ctrl_state_e;

   typedef struct packed {
      logic pc_load;
      logic if_id_load;
      logic id_ex_load;
      logic ex_mem_load;
      logic mem_wb_load;
      logic if_id_flush;
      logic id_ex_flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RESET  = 7'b00000_11;
   localparam pipe_ctrl_t CTRL_FREEZE = 7'b00000_00;
   localparam pipe_ctrl_t CTRL_FLUSH  = 7'b11111_11;
   localparam pipe_ctrl_t CTRL_BUBBLE = 7'b00111_01;
   localparam pipe_ctrl_t CTRL_GO     = 7'b11111_00;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: ID reads a register a load in EX will write.
// In: id_rs1/id_rs2/id_use_rs1/id_use_rs2, ex_rd, ex_is_load. Out: load_use.
module hazard_detect (
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_is_load,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
   assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);

   // x0 is never written, so a load to it cannot be a hazard
   assign load_use = ex_is_load & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with stall/flush counters.
// In: ID/EX hazard fields, branch redirect, I/D mem responses. Out: loads, flushes, state, counters.
module pipeline_ctrl
   import rv32i_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_br_taken,
   input  logic             imem_resp,
   input  logic             mem_dmem_active,
   input  logic             dmem_resp,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   pipe_ctrl_state_e state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   pipe_ctrl_t ctrl;
   logic       load_use;
   logic       mem_stall;

   hazard_detect u_hazard (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_is_load (ex_is_load),
      .load_use   (load_use)
   );

   assign mem_stall = ~imem_resp | (mem_dmem_active & ~dmem_resp);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= INIT;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Deferred branch/load-use during a freeze need no extra state:
   // their inputs are held, so they re-evaluate once the freeze ends.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         INIT: state_d = RUN;
         RUN, MEM_STALL, LU_STALL: begin
            if (mem_stall) begin
               state_d     = MEM_STALL;
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else if (ex_br_taken) begin
               state_d     = RUN;
               flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (load_use) begin
               state_d     = LU_STALL;
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   always_comb begin
      ctrl = CTRL_RESET;
      if (rst) begin
         unique case (state_q)
            INIT: ctrl = CTRL_RESET;
            RUN, MEM_STALL, LU_STALL: begin
               if (mem_stall)        ctrl = CTRL_FREEZE;
               else if (ex_br_taken) ctrl = CTRL_FLUSH;
               else if (load_use)    ctrl = CTRL_BUBBLE;
               else                  ctrl = CTRL_GO;
            end
         endcase
      end
   end

   assign pc_load     = ctrl.pc_load;
   assign if_id_load  = ctrl.if_id_load;
   assign id_ex_load  = ctrl.id_ex_load;
   assign ex_mem_load = ctrl.ex_mem_load;
   assign mem_wb_load = ctrl.mem_wb_load;
   assign if_id_flush = ctrl.if_id_flush;
   assign id_ex_flush = ctrl.id_ex_flush;
   assign ctrl_state  = rst ? state_q : INIT;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with a cycle-level reference model.
// Driver pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

   localparam int CNT_W = 6;
   localparam int MOD   = 1 << CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [4:0]       id_rs1 = '0;
   logic [4:0]       id_rs2 = '0;
   logic             id_use_rs1 = 1'b0;
   logic             id_use_rs2 = 1'b0;
   logic [4:0]       ex_rd = '0;
   logic             ex_is_load = 1'b0;
   logic             ex_br_taken = 1'b0;
   logic             imem_resp = 1'b1;
   logic             mem_dmem_active = 1'b0;
   logic             dmem_resp = 1'b1;
   logic             pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic             if_id_flush, id_ex_flush;
   logic [1:0]       ctrl_state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_rd           (ex_rd),
      .ex_is_load      (ex_is_load),
      .ex_br_taken     (ex_br_taken),
      .imem_resp       (imem_resp),
      .mem_dmem_active (mem_dmem_active),
      .dmem_resp       (dmem_resp),
      .pc_load         (pc_load),
      .if_id_load      (if_id_load),
      .id_ex_load      (id_ex_load),
      .ex_mem_load     (ex_mem_load),
      .mem_wb_load     (mem_wb_load),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ctrl_state      (ctrl_state),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   // ctl = {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id_flush, id_ex_flush}
   typedef struct {
      logic [6:0] ctl;
      int         st;
      int         sc;
      int         fc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // model: 0=INIT 1=RUN 2=MEM_STALL 3=LU_STALL
   int m_st = 0;
   int m_sc = 0;
   int m_fc = 0;

   task automatic step(input bit r, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit [4:0] rd,
                       input bit ld, input bit br, input bit imr,
                       input bit dact, input bit dr);
      exp_t e;
      bit   ms, lu;
      @(posedge clk);
      #2;
      rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_rd = rd; ex_is_load = ld; ex_br_taken = br; imem_resp = imr;
      mem_dmem_active = dact; dmem_resp = dr;
      if (!r) begin
         m_st = 0; m_sc = 0; m_fc = 0;
         e.ctl = 7'b0000011; e.st = 0; e.sc = 0; e.fc = 0;
      end else if (m_st == 0) begin
         e.ctl = 7'b0000011; e.st = 0; e.sc = m_sc; e.fc = m_fc;
         m_st = 1;
      end else begin
         e.st = m_st; e.sc = m_sc; e.fc = m_fc;
         ms = !imr || (dact && !dr);
         lu = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
         if (ms) begin
            e.ctl = 7'b0000000; m_st = 2; m_sc = (m_sc + 1) % MOD;
         end else if (br) begin
            e.ctl = 7'b1111111; m_st = 1; m_fc = (m_fc + 1) % MOD;
         end else if (lu) begin
            e.ctl = 7'b0011101; m_st = 3; m_sc = (m_sc + 1) % MOD;
         end else begin
            e.ctl = 7'b1111100; m_st = 1;
         end
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
   endtask

   always @(negedge clk) begin
      exp_t       e;
      logic [6:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_flush, id_ex_flush};
         total++;
         if (act !== e.ctl) begin
            bad++;
            $display("FAIL ctl t=%0t got=%b exp=%b", $time, act, e.ctl);
         end
         total++;
         if (ctrl_state !== 2'(e.st)) begin
            bad++;
            $display("FAIL state t=%0t got=%0d exp=%0d", $time, ctrl_state, e.st);
         end
         total++;
         if (stall_cnt !== CNT_W'(e.sc)) begin
            bad++;
            $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.sc);
         end
         total++;
         if (flush_cnt !== CNT_W'(e.fc)) begin
            bad++;
            $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, flush_cnt, e.fc);
         end
      end
   end

   initial begin
      // reset for 3 cycles, then INIT, then RUN
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      idle(3);
      // load-use on rs2
      step(1, 0, 5, 0, 1, 5, 1, 0, 1, 0, 1);
      idle(2);
      // load to x0 never stalls
      step(1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1);
      idle(1);
      // D-miss for 4 cycles with branch pending, then release
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
      idle(1);
      // branch and load-use together
      step(1, 3, 0, 1, 0, 3, 1, 1, 1, 0, 1);
      idle(1);
      // I-miss run long enough to wrap the stall counter
      for (int i = 0; i < MOD + 3; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // async reset while in MEM_STALL
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      idle(2);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(99) != 0),
              5'($urandom_range(3)), 5'($urandom_range(3)),
              1'($urandom), 1'($urandom), 5'($urandom_range(3)),
              1'($urandom), ($urandom_range(5) == 0),
              ($urandom_range(7) != 0), 1'($urandom),
              ($urandom_range(3) != 0));
      end
      idle(2);
      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(posedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Generates load enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus bubble/flush controls for IF/ID and ID/EX.
- Inputs: decode-stage register usage, EX-stage load/branch status, and I/D memory response handshakes.
- Keeps performance counters for stall and flush cycles.

Parameters:
- CNT_W, 32, width of performance counters (wrap modulo 2^CNT_W).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch/jump (redirect)
- imem_resp  in  1  instruction fetch complete this cycle
- mem_dmem_active  in  1  MEM-stage instruction accesses data memory
- dmem_resp  in  1  data access complete this cycle
- pc_load  out  1  advance PC
- if_id_load  out  1  load IF/ID
- id_ex_load  out  1  load ID/EX
- ex_mem_load  out  1  load EX/MEM
- mem_wb_load  out  1  load MEM/WB
- if_id_flush  out  1  replace IF/ID contents with NOP
- id_ex_flush  out  1  replace ID/EX contents with NOP (bubble)
- ctrl_state  out  2  current FSM state (debug)
- stall_cnt  out  CNT_W  cycles with pc_load=0 outside INIT
- flush_cnt  out  CNT_W  number of redirect flushes

Behaviour:
- States: INIT, RUN, MEM_STALL, LU_STALL. The state register and counters are the only flops; all other outputs are combinational from the state and inputs.
- Reset (rst=0, asynchronous): state=INIT, stall_cnt=0, flush_cnt=0.
  - While in reset: all loads=0, both flushes=1, ctrl_state=INIT.
- INIT (exactly one cycle after reset release):
  - Loads=0, if_id_flush=1, id_ex_flush=1.
  - Next state RUN. No counters increment.
- mem_stall = (!imem_resp) | (mem_dmem_active & !dmem_resp).
- load_use = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN/MEM_STALL/LU_STALL: mem_stall > ex_br_taken > load_use.
  - mem_stall: all five loads=0, flushes=0 (full freeze). Next state MEM_STALL; stall_cnt++. Branch and load-use are deferred; they are re-evaluated from held inputs when the pipeline unfreezes.
  - ex_br_taken: all loads=1, if_id_flush=1, id_ex_flush=1. Next state RUN; flush_cnt++. Load-use in the same cycle is ignored because the ID instruction is squashed.
  - load_use: pc_load=0, if_id_load=0, id_ex_load=1, id_ex_flush=1, ex_mem_load=1, mem_wb_load=1. Next state LU_STALL; stall_cnt++.
  - None of the above: all loads=1, flushes=0. Next state RUN.
- LU_STALL lasts exactly one cycle unless mem_stall occurs. The bubble now in EX has ex_is_load=0, so the hazard cannot re-trigger.
- Flush outputs assert only together with their stage's load=1 (except INIT/reset). The register applies the flush on the load edge.
- Counters wrap from 2^CNT_W-1 to 0. No saturation.
- Reset asserted mid-stall: immediate return to INIT; counters clear.
- ex_rd=0 never produces a load-use stall.

Decomposition:
- rv32i_types gets:
  - pipe_ctrl_state_e (INIT=0, RUN=1, MEM_STALL=2, LU_STALL=3).
  - pipe_ctrl_t struct bundling the five loads and two flushes, for later reuse in the stage wrappers.
- One natural sub-module: hazard_detect. It is purely combinational, computes load_use from the ID/EX fields, and is reused when forwarding is added.

Test Plan:
- Reset: hold rst=0 3 cycles, release → one INIT cycle (loads=0, flushes=1, state=0), then RUN with all loads=1, counters 0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1, both resp=1 → one cycle of pc_load=0, if_id_load=0, id_ex_flush=1; stall_cnt=1; next cycle RUN.
- ex_rd=0 with id_rs1=0, id_use_rs1=1, ex_is_load=1 → no stall, stall_cnt unchanged.
- D-miss: mem_dmem_active=1, dmem_resp=0 for 4 cycles with ex_br_taken=1 → all loads=0 for 4 cycles, stall_cnt=4. On dmem_resp=1, flush asserts once and flush_cnt=1.
- Branch + load-use same cycle → if_id_flush=id_ex_flush=1, pc_load=1, flush_cnt++, stall_cnt unchanged.
- Preload stall_cnt to 2^CNT_W-1 via force, cause stall → wraps to 0. Assert rst mid-MEM_STALL → outputs go to reset values asynchronously.
